// File: rtl/hilo_acc_reg.sv
// HI/LO architectural register pair for the execute stage: direct writes
// (MTHI/MTLO/MULT/DIV results) plus a two-cycle MADD/MSUB accumulate.
module hilo_acc_reg #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flushE,
  input  logic          valid_i,
  input  logic [2:0]    op_i,
  input  logic [DW-1:0] hi_i,
  input  logic [DW-1:0] lo_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [DW-1:0] hi_o,
  output logic [DW-1:0] lo_o
);

  localparam logic [2:0] OP_WHI   = 3'd1;
  localparam logic [2:0] OP_WLO   = 3'd2;
  localparam logic [2:0] OP_WBOTH = 3'd3;
  localparam logic [2:0] OP_MADD  = 3'd4;
  localparam logic [2:0] OP_MSUB  = 3'd5;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;

  state_t            state_r, state_s;
  logic [DW-1:0]     hi_r, lo_r;
  logic [2*DW-1:0]   opnd_r;
  logic              sub_r;
  logic [2*DW-1:0]   acc_s;
  logic              op_ok_s, write_s, start_s, accept_s;

  // Classify the requested op; 0, 6 and 7 are never accepted.
  always_comb begin
    op_ok_s = 1'b0;
    write_s = 1'b0;
    start_s = 1'b0;
    case (op_i)
      OP_WHI, OP_WLO, OP_WBOTH: begin
        op_ok_s = 1'b1;
        write_s = 1'b1;
      end
      OP_MADD, OP_MSUB: begin
        op_ok_s = 1'b1;
        start_s = 1'b1;
      end
      default: begin
        op_ok_s = 1'b0;
      end
    endcase
  end

  assign accept_s = valid_i & ~flushE & (state_r == IDLE) & op_ok_s;

  // Next-state and handshake outputs; the ACC cycle is the commit cycle.
  always_comb begin
    state_s = state_r;
    busy_o  = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s && start_s) begin
          state_s = ACC;
        end else begin
          state_s = IDLE;
        end
      end
      ACC: begin
        busy_o  = 1'b1;
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    done_o = ~rst & ((accept_s & write_s) | busy_o);
  end

  // Full-width add/sub so the lo->hi carry or borrow falls out naturally.
  always_comb begin
    if (sub_r) begin
      acc_s = {hi_r, lo_r} - opnd_r;
    end else begin
      acc_s = {hi_r, lo_r} + opnd_r;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // HI/LO and accumulate stage registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_r   <= {DW{1'b0}};
      lo_r   <= {DW{1'b0}};
      opnd_r <= {(2*DW){1'b0}};
      sub_r  <= 1'b0;
    end else if (state_r == ACC) begin
      {hi_r, lo_r} <= acc_s;
    end else if (accept_s) begin
      case (op_i)
        OP_WHI:   hi_r <= hi_i;
        OP_WLO:   lo_r <= lo_i;
        OP_WBOTH: begin
          hi_r <= hi_i;
          lo_r <= lo_i;
        end
        OP_MADD: begin
          opnd_r <= {hi_i, lo_i};
          sub_r  <= 1'b0;
        end
        OP_MSUB: begin
          opnd_r <= {hi_i, lo_i};
          sub_r  <= 1'b1;
        end
        default: begin
          hi_r <= hi_r;
        end
      endcase
    end
  end

  assign hi_o = hi_r;
  assign lo_o = lo_r;

endmodule

// File: tb/tb_hilo_acc_reg.sv
// Self-checking bench for hilo_acc_reg: directed scenarios plus a randomized
// run against a transaction-level model of the {hi,lo} accumulator.
module tb_hilo_acc_reg;

  logic        clk;
  logic        rst;
  logic        flushE;
  logic        valid_i;
  logic [2:0]  op_i;
  logic [31:0] hi_i;
  logic [31:0] lo_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int n_run  = 0;
  int n_fail = 0;

  // Reference model: one 64-bit architectural value and an optional pending accumulate.
  logic [63:0] acc_m;
  logic        pend_m;
  logic        sub_m;
  logic [63:0] opnd_m;

  logic b_obs, d_obs, b_exp, d_exp;

  hilo_acc_reg #(.DW(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .flushE (flushE),
    .valid_i(valid_i),
    .op_i   (op_i),
    .hi_i   (hi_i),
    .lo_i   (lo_i),
    .busy_o (busy_o),
    .done_o (done_o),
    .hi_o   (hi_o),
    .lo_o   (lo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle, record observed/expected handshake, advance model at the edge.
  task automatic cyc(input logic v, input logic [2:0] op, input logic [31:0] h,
                     input logic [31:0] l, input logic fl, input logic r);
    logic acc_ok;
    valid_i = v; op_i = op; hi_i = h; lo_i = l; flushE = fl; rst = r;
    #1;
    b_obs  = busy_o;
    d_obs  = done_o;
    acc_ok = v && !fl && !pend_m && (op >= 3'd1) && (op <= 3'd5);
    b_exp  = pend_m;
    d_exp  = !r && (pend_m || (acc_ok && op <= 3'd3));
    @(posedge clk);
    if (r) begin
      acc_m  = 64'd0;
      pend_m = 1'b0;
    end else if (pend_m) begin
      acc_m  = sub_m ? acc_m - opnd_m : acc_m + opnd_m;
      pend_m = 1'b0;
    end else if (acc_ok) begin
      case (op)
        3'd1: acc_m[63:32] = h;
        3'd2: acc_m[31:0]  = l;
        3'd3: acc_m        = {h, l};
        default: begin
          pend_m = 1'b1;
          sub_m  = (op == 3'd5);
          opnd_m = {h, l};
        end
      endcase
    end
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    cyc(1'b1, 3'd3, 32'h1111_1111, 32'h2222_2222, 1'b0, 1'b1);
    cyc(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    n_run++; if (d_obs !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", d_obs); end
    idle();
    n_run++; if (hi_o !== 32'd0) begin n_fail++; $display("FAIL reset_hi: got %h want 0", hi_o); end
    n_run++; if (lo_o !== 32'd0) begin n_fail++; $display("FAIL reset_lo: got %h want 0", lo_o); end
    n_run++; if (b_obs !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", b_obs); end
    n_run++; if (d_obs !== 1'b0) begin n_fail++; $display("FAIL reset_done2: got %b want 0", d_obs); end
  endtask

  task automatic test_idle_ops();
    logic [2:0] ops [3];
    ops[0] = 3'd0; ops[1] = 3'd6; ops[2] = 3'd7;
    cyc(1'b1, 3'd3, 32'hA5A5_0001, 32'h5A5A_0002, 1'b0, 1'b0);
    foreach (ops[i]) begin
      cyc(1'b1, ops[i], 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
      n_run++; if (d_obs !== 1'b0) begin n_fail++; $display("FAIL nop_done op%0d: got %b want 0", ops[i], d_obs); end
      n_run++; if ({hi_o, lo_o} !== 64'hA5A5_0001_5A5A_0002) begin
        n_fail++; $display("FAIL nop_hold op%0d: got %h%h want a5a500015a5a0002", ops[i], hi_o, lo_o); end
    end
  endtask

  task automatic test_independent_writes();
    cyc(1'b1, 3'd1, 32'hDEAD_BEEF, 32'h0BAD_0BAD, 1'b0, 1'b0);
    n_run++; if (d_obs !== 1'b1) begin n_fail++; $display("FAIL whi_done: got %b want 1", d_obs); end
    n_run++; if (hi_o !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL whi_hi: got %h want deadbeef", hi_o); end
    n_run++; if (lo_o !== 32'h5A5A_0002) begin n_fail++; $display("FAIL whi_lo_kept: got %h want 5a5a0002", lo_o); end
    idle();
    n_run++; if (d_obs !== 1'b0) begin n_fail++; $display("FAIL whi_done_once: got %b want 0", d_obs); end
    cyc(1'b1, 3'd2, 32'h0BAD_0BAD, 32'h1234_5678, 1'b0, 1'b0);
    n_run++; if (d_obs !== 1'b1) begin n_fail++; $display("FAIL wlo_done: got %b want 1", d_obs); end
    n_run++; if (lo_o !== 32'h1234_5678) begin n_fail++; $display("FAIL wlo_lo: got %h want 12345678", lo_o); end
    n_run++; if (hi_o !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wlo_hi_kept: got %h want deadbeef", hi_o); end
  endtask

  task automatic test_flush();
    cyc(1'b1, 3'd3, 32'h1, 32'h2, 1'b1, 1'b0);
    n_run++; if (d_obs !== 1'b0) begin n_fail++; $display("FAIL flush_done: got %b want 0", d_obs); end
    n_run++; if ({hi_o, lo_o} !== 64'hDEAD_BEEF_1234_5678) begin
      n_fail++; $display("FAIL flush_hold: got %h%h want deadbeef12345678", hi_o, lo_o); end
    cyc(1'b1, 3'd3, 32'h1, 32'h2, 1'b0, 1'b0);
    n_run++; if (d_obs !== 1'b1) begin n_fail++; $display("FAIL wboth_done: got %b want 1", d_obs); end
    n_run++; if (hi_o !== 32'h1 || lo_o !== 32'h2) begin
      n_fail++; $display("FAIL wboth_val: got %h/%h want 1/2", hi_o, lo_o); end
  endtask

  task automatic test_madd_carry();
    cyc(1'b1, 3'd3, 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    cyc(1'b1, 3'd4, 32'h0, 32'h1, 1'b0, 1'b0);
    n_run++; if (b_obs !== 1'b0 || d_obs !== 1'b0) begin
      n_fail++; $display("FAIL madd_accept: got busy=%b done=%b want 0/0", b_obs, d_obs); end
    n_run++; if (hi_o !== 32'h0 || lo_o !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL madd_old: got %h/%h want 0/ffffffff", hi_o, lo_o); end
    cyc(1'b1, 3'd1, 32'h77, 32'h0, 1'b0, 1'b0);
    n_run++; if (b_obs !== 1'b1 || d_obs !== 1'b1) begin
      n_fail++; $display("FAIL madd_acc: got busy=%b done=%b want 1/1", b_obs, d_obs); end
    n_run++; if (hi_o !== 32'h1 || lo_o !== 32'h0) begin
      n_fail++; $display("FAIL madd_carry: got %h/%h want 1/0", hi_o, lo_o); end
    idle();
    n_run++; if (b_obs !== 1'b0) begin n_fail++; $display("FAIL madd_busy_len: got %b want 0", b_obs); end
    n_run++; if (hi_o !== 32'h1) begin n_fail++; $display("FAIL madd_whi_ignored: got %h want 1", hi_o); end
  endtask

  task automatic test_msub_borrow();
    cyc(1'b1, 3'd3, 32'h0, 32'h0, 1'b0, 1'b0);
    cyc(1'b1, 3'd5, 32'h0, 32'h1, 1'b0, 1'b0);
    cyc(1'b1, 3'd3, 32'h9, 32'h9, 1'b1, 1'b0);
    n_run++; if (b_obs !== 1'b1 || d_obs !== 1'b1) begin
      n_fail++; $display("FAIL msub_acc: got busy=%b done=%b want 1/1", b_obs, d_obs); end
    n_run++; if (hi_o !== 32'hFFFF_FFFF || lo_o !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL msub_wrap: got %h/%h want ffffffff/ffffffff", hi_o, lo_o); end
  endtask

  task automatic test_reset_mid_acc();
    cyc(1'b1, 3'd3, 32'h5, 32'h6, 1'b0, 1'b0);
    cyc(1'b1, 3'd4, 32'h1, 32'h1, 1'b0, 1'b0);
    cyc(1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 1'b1);
    n_run++; if (d_obs !== 1'b0) begin n_fail++; $display("FAIL rstacc_done: got %b want 0", d_obs); end
    n_run++; if (hi_o !== 32'h0 || lo_o !== 32'h0) begin
      n_fail++; $display("FAIL rstacc_val: got %h/%h want 0/0", hi_o, lo_o); end
    idle();
    n_run++; if (b_obs !== 1'b0 || d_obs !== 1'b0) begin
      n_fail++; $display("FAIL rstacc_after: got busy=%b done=%b want 0/0", b_obs, d_obs); end
  endtask

  task automatic test_back_to_back();
    cyc(1'b1, 3'd3, 32'h10, 32'h20, 1'b0, 1'b0);
    cyc(1'b1, 3'd4, 32'h1, 32'h2, 1'b0, 1'b0);
    cyc(1'b1, 3'd4, 32'h100, 32'h200, 1'b0, 1'b0);
    n_run++; if (hi_o !== 32'h11 || lo_o !== 32'h22) begin
      n_fail++; $display("FAIL b2b_madd: got %h/%h want 11/22", hi_o, lo_o); end
    cyc(1'b1, 3'd3, 32'hCAFE, 32'hF00D, 1'b0, 1'b0);
    n_run++; if (b_obs !== 1'b0 || d_obs !== 1'b1) begin
      n_fail++; $display("FAIL b2b_wboth: got busy=%b done=%b want 0/1", b_obs, d_obs); end
    n_run++; if (hi_o !== 32'hCAFE || lo_o !== 32'hF00D) begin
      n_fail++; $display("FAIL b2b_val: got %h/%h want cafe/f00d", hi_o, lo_o); end
  endtask

  task automatic test_random();
    logic [31:0] h, l;
    for (int i = 0; i < 400; i++) begin
      h = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      l = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      cyc(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), h, l,
          ($urandom_range(0, 4) == 0), ($urandom_range(0, 39) == 0));
      n_run++; if (b_obs !== b_exp) begin n_fail++; $display("FAIL rnd_busy @%0d: got %b want %b", i, b_obs, b_exp); end
      n_run++; if (d_obs !== d_exp) begin n_fail++; $display("FAIL rnd_done @%0d: got %b want %b", i, d_obs, d_exp); end
      n_run++; if ({hi_o, lo_o} !== acc_m) begin
        n_fail++; $display("FAIL rnd_hilo @%0d: got %h%h want %h", i, hi_o, lo_o, acc_m); end
    end
  endtask

  initial begin
    acc_m = 64'd0; pend_m = 1'b0; sub_m = 1'b0; opnd_m = 64'd0;
    rst = 1'b1; flushE = 1'b0; valid_i = 1'b0; op_i = 3'd0; hi_i = 32'd0; lo_i = 32'd0;
    test_reset();
    test_idle_ops();
    test_independent_writes();
    test_flush();
    test_madd_carry();
    test_msub_borrow();
    test_reset_mid_acc();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/hilo_acc_reg.md
Name: hilo_acc_reg

Overview:
Parametrised HI/LO register for the execute stage. It supports independent HI-only and LO-only writes (MTHI/MTLO) and a joint write (MULT/DIV result). It also supports two-cycle accumulate modes (MADD/MSUB) that add a 2*DW operand to, or subtract it from, the concatenated {hi,lo}. It sits beside the ALU/multiplier and feeds MFHI/MFLO. It provides busy back-pressure to the hazard unit and respects flushE.

Parameters:
DW, 32, width of each of HI and LO.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous, active-high reset.
flushE  in  1  execute-stage flush; suppresses acceptance of the current request.
valid_i  in  1  request present this cycle.
op_i  in  3  operation: 0 NOP, 1 WHI, 2 WLO, 3 WBOTH, 4 MADD, 5 MSUB, 6/7 reserved (treated as NOP).
hi_i  in  DW  HI operand / upper half of accumulate operand.
lo_i  in  DW  LO operand / lower half of accumulate operand.
busy_o  out  1  accumulate in flight; no request accepted this cycle.
done_o  out  1  one-cycle pulse in the cycle whose clock edge commits a write.
hi_o  out  DW  architectural HI.
lo_o  out  DW  architectural LO.

Behaviour:
- Reset (clk edge with rst=1): hi=0, lo=0, pending accumulate cleared, busy_o=0, done_o=0. rst overrides every other input, including a request in the same cycle and an accumulate in flight, which is discarded.
- Accept condition: accept = valid_i & ~flushE & ~busy_o & (op_i in 1..5). Ops 0, 6 and 7 are never accepted and cause no state change.
- WHI: at the accept edge, hi <= hi_i; lo unchanged. done_o=1 in the accept cycle (combinational from accept).
- WLO: at the accept edge, lo <= lo_i; hi unchanged. done_o=1 in the accept cycle.
- WBOTH: at the accept edge, hi <= hi_i and lo <= lo_i. done_o=1 in the accept cycle.
- Writes are visible on hi_o/lo_o from the cycle after the accept edge. No same-cycle bypass.
- MADD/MSUB FSM states: IDLE, ACC.
  - IDLE -> ACC on an accepted op 4/5. At that edge, capture operand {hi_i,lo_i} and the add/sub select into stage registers. hi/lo are unchanged.
  - In ACC: busy_o=1 and done_o=1. At the next edge, {hi,lo} <= {hi,lo} ± operand, computed modulo 2^(2*DW) with carry/borrow out discarded (the signed and unsigned forms are identical at this level). The carry from lo into hi propagates. The state then returns to IDLE.
  - Total latency is 2 edges from accept to the new value. hi_o/lo_o hold the old value throughout the ACC cycle.
- flushE affects acceptance only. An accumulate already in ACC always completes, because the instruction has left E. flushE asserted during ACC has no effect.
- Requests presented while busy_o=1 are ignored, not queued. The hazard unit must stall E on busy_o.
- done_o is 0 in every other cycle and during reset.
- Back-to-back operation: a WBOTH in the cycle after ACC completes is accepted normally (busy_o drops immediately after the commit edge). Consecutive MADDs are therefore accepted at most every 2 cycles.

Test Plan:
- Reset then idle: rst high for 2 cycles, then low -> hi_o=0, lo_o=0, busy_o=0, done_o=0. Ops 0, 6 and 7 with valid_i=1 leave the values unchanged.
- Independent writes: WHI hi_i=0xDEADBEEF, then WLO lo_i=0x12345678 -> hi_o=0xDEADBEEF, lo_o=0x12345678; each write shows done_o pulsed once and leaves the other half untouched.
- flushE suppression: WBOTH 0x1/0x2 with flushE=1 -> registers unchanged, done_o=0. Repeat with flushE=0 -> hi_o=1, lo_o=2.
- MADD carry: hi=0, lo=0xFFFFFFFF, MADD {0,1} -> busy_o=1 for exactly 1 cycle; hi_o=1, lo_o=0 two cycles after accept. A WHI issued during busy is ignored.
- MSUB borrow/wrap: hi=0, lo=0, MSUB {0,1} -> hi_o=0xFFFFFFFF, lo_o=0xFFFFFFFF. flushE=1 asserted during ACC does not cancel the result.
- Reset mid-accumulate: MADD accepted, rst=1 in the ACC cycle -> hi_o=0, lo_o=0, busy_o=0 next cycle, no done_o after reset.
